// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-master arbiter and IDLE/ACCESS/DONE sequencer for one memory port
// Ports: clock, reset (sync, active-high)
//   m0_*/m1_*: req, rw (1=read), addr, wdata in; gnt, done, err out
//   mem_*: valid, rw, addr, wdata out; rdata, ready in
//   rdata: last read data; owner: current/most recent master; busy: not idle
// Optional: ARB_TIMEOUT_EN enables the TIMEOUT-cycle abort path
module mem_arbiter #(
    parameter int WIDTH = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             m0_req,
    input  logic             m0_rw,
    input  logic [WIDTH-1:0] m0_addr,
    input  logic [WIDTH-1:0] m0_wdata,
    input  logic             m1_req,
    input  logic             m1_rw,
    input  logic [WIDTH-1:0] m1_addr,
    input  logic [WIDTH-1:0] m1_wdata,
    output logic             m0_gnt,
    output logic             m0_done,
    output logic             m0_err,
    output logic             m1_gnt,
    output logic             m1_done,
    output logic             m1_err,
    output logic [WIDTH-1:0] rdata,
    output logic             mem_valid,
    output logic             mem_rw,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready,
    output logic             owner,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;
    state_t state, state_nxt;
    logic pick, any_req, timed_out;
`ifdef ARB_TIMEOUT_EN
    logic [4:0] cnt;
    logic err_q;
    assign timed_out = cnt == 5'(TIMEOUT - 1);
`else
    assign timed_out = 1'b0;
`endif
    assign any_req = m0_req | m1_req;
    // on a tie the master that did not own the previous transaction wins
    assign pick = (m0_req && m1_req) ? ~owner : m1_req;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = any_req ? ACCESS : IDLE;
            ACCESS:  state_nxt = (mem_ready || timed_out) ? DONE : ACCESS;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            owner <= 1'b1;
            rdata <= '0;
            mem_rw <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt <= '0;
            err_q <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_req) begin
                owner <= pick;
                mem_rw <= pick ? m1_rw : m0_rw;
                mem_addr <= pick ? m1_addr : m0_addr;
                mem_wdata <= pick ? m1_wdata : m0_wdata;
`ifdef ARB_TIMEOUT_EN
                cnt <= '0;
                err_q <= 1'b0;
`endif
            end
            if (state == ACCESS && mem_ready && mem_rw)
                rdata <= mem_rdata;
`ifdef ARB_TIMEOUT_EN
            // ready on the final cycle takes precedence over the abort
            if (state == ACCESS && !mem_ready) begin
                if (timed_out)
                    err_q <= 1'b1;
                else
                    cnt <= cnt + 5'd1;
            end
`endif
        end
    end
    assign mem_valid = state == ACCESS;
    assign busy = state != IDLE;
    assign m0_gnt = mem_valid && !owner;
    assign m1_gnt = mem_valid && owner;
    assign m0_done = state == DONE && !owner;
    assign m1_done = state == DONE && owner;
`ifdef ARB_TIMEOUT_EN
    assign m0_err = m0_done && err_q;
    assign m1_err = m1_done && err_q;
`else
    assign m0_err = 1'b0;
    assign m1_err = 1'b0;
`endif
endmodule
